// File: rtl/sqg_pkg.sv
// Shared definitions for the 2x2 grid-transfer blocks (restriction and prolongation).
// Holds the state encoding, data width and grid-geometry helpers.
package sqg_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } sqg_state_e;

    function automatic int coarse_side(input int box_idx);
        return 1 << (box_idx - 1);
    endfunction

    function automatic int coarse_aw(input int box_idx);
        return 2 * (box_idx - 1);
    endfunction

    function automatic int fine_aw(input int box_idx);
        return 2 * box_idx;
    endfunction

endpackage

// File: rtl/sqp_addr_gen.sv
// Coarse/fine address generator for the prolongation engine.
// Walks cx (fastest) and cy with a 2-bit phase selecting the fine cell of each 2x2 block.
module sqp_addr_gen
    import sqg_pkg::*;
#(
    parameter int BOX_IDX = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          adv,
    output logic [1:0]                    phase,
    output logic [coarse_aw(BOX_IDX)-1:0] rd_addr,
    output logic [fine_aw(BOX_IDX)-1:0]   wr_addr,
    output logic                          last_cell
);

    localparam int CW = BOX_IDX - 1;
    localparam logic [CW-1:0] C_MAX = CW'(coarse_side(BOX_IDX) - 1);

    logic [CW-1:0] cx;
    logic [CW-1:0] cy;
    logic [CW-1:0] cx_nxt;
    logic [CW-1:0] cy_nxt;
    logic          row_end;

    assign row_end   = (cx == C_MAX);
    assign cx_nxt    = cx + 1'b1;
    assign cy_nxt    = row_end ? cy + 1'b1 : cy;
    assign last_cell = row_end && (cy == C_MAX) && (phase == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx    <= '0;
            cy    <= '0;
            phase <= 2'd0;
        end else if (clr) begin
            cx    <= '0;
            cy    <= '0;
            phase <= 2'd0;
        end else if (adv) begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) begin
                cx <= cx_nxt;
                cy <= cy_nxt;
            end
        end
    end

    // Phase 3 looks ahead one cell so the RAM data lands exactly on the next phase 0.
    assign rd_addr = (phase == 2'd3) ? {cx_nxt, cy_nxt} : {cx, cy};
    assign wr_addr = {cx, phase[0], cy, phase[1]};

endmodule

// File: rtl/sqp.sv
// Prolongation engine: copies each coarse cell, right-shifted by SCALE_SHIFT,
// into the four fine cells of its 2x2 block. Coarse RAM has one cycle of read latency.
//
//   state | meaning
//   IDLE  | waiting for start, outputs quiet
//   PRIME | first coarse address presented, data not yet back
//   WRITE | four fine writes per coarse cell (phase 0..3)
//   DONE  | one-cycle completion pulse
module sqp
    import sqg_pkg::*;
#(
    parameter int BOX_IDX     = 3,
    parameter int SCALE_SHIFT = 0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          BC_mode,
    input  logic                          start,
    input  logic [DATA_W-1:0]             x,
    output logic [coarse_aw(BOX_IDX)-1:0] rd_addr,
    output logic [fine_aw(BOX_IDX)-1:0]   wr_addr,
    output logic                          wen,
    output logic [DATA_W-1:0]             y,
    output logic                          busy,
    output logic                          done
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_PRIME = PRIME;
    localparam logic [1:0] S_WRITE = WRITE;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] src;
    logic [1:0]        phase;
    logic              last_cell;

    sqp_addr_gen #(
        .BOX_IDX (BOX_IDX)
    ) u_addr_gen (
        .clk       (CLK),
        .rst       (RST),
        .clr       (BC_mode),
        .adv       (state == S_WRITE),
        .phase     (phase),
        .rd_addr   (rd_addr),
        .wr_addr   (wr_addr),
        .last_cell (last_cell)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_PRIME;
            S_PRIME: state_nxt = S_WRITE;
            S_WRITE: if (last_cell) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            hold  <= '0;
        end else if (BC_mode) begin
            state <= S_IDLE;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WRITE && phase == 2'd0) hold <= x;
        end
    end

    // Phase 0 uses the RAM data as it arrives; later phases replay the captured copy.
    assign src  = (phase == 2'd0) ? x : hold;
    assign y    = (state == S_WRITE) ? (src >> SCALE_SHIFT) : '0;
    assign wen  = (state == S_WRITE);
    assign busy = (state == S_PRIME) || (state == S_WRITE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_sqp.sv
// Bench for sqp: three instances (BOX_IDX=3/SHIFT=0, BOX_IDX=3/SHIFT=2, BOX_IDX=2/SHIFT=0)
// checked every cycle against a cycle-index model, plus directed literal checks.
module tb_sqp;

    typedef struct {
        logic [31:0] wen;
        logic [31:0] busy;
        logic [31:0] done;
        logic [31:0] y;
        logic [31:0] wr;
        logic [31:0] rd;
    } outs_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic BC_mode = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic [7:0] x_a = 8'd0, x_b = 8'd0, x_c = 8'd0;
    logic [7:0] y_a, y_b, y_c;
    logic [3:0] rd_a, rd_b;
    logic [1:0] rd_c;
    logic [5:0] wr_a, wr_b;
    logic [3:0] wr_c;
    logic wen_a, wen_b, wen_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sqp #(.BOX_IDX(3), .SCALE_SHIFT(0)) dut_a (
        .CLK(CLK), .RST(RST), .BC_mode(BC_mode), .start(start_a), .x(x_a),
        .rd_addr(rd_a), .wr_addr(wr_a), .wen(wen_a), .y(y_a), .busy(busy_a), .done(done_a));

    sqp #(.BOX_IDX(3), .SCALE_SHIFT(2)) dut_b (
        .CLK(CLK), .RST(RST), .BC_mode(BC_mode), .start(start_b), .x(x_b),
        .rd_addr(rd_b), .wr_addr(wr_b), .wen(wen_b), .y(y_b), .busy(busy_b), .done(done_b));

    sqp #(.BOX_IDX(2), .SCALE_SHIFT(0)) dut_c (
        .CLK(CLK), .RST(RST), .BC_mode(BC_mode), .start(start_c), .x(x_c),
        .rd_addr(rd_c), .wr_addr(wr_c), .wen(wen_c), .y(y_c), .busy(busy_c), .done(done_c));

    function automatic int box_of(input int i);
        return (i == 2) ? 2 : 3;
    endfunction

    function automatic int shift_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    // Coarse RAM contents per instance.
    function automatic int pat(input int i, input int cx, input int cy);
        if (i == 1) return (cx == 2 && cy == 1) ? 255 : ((16 * cy + cx + 128) & 255);
        return 16 * cy + cx;
    endfunction

    always @(posedge CLK) begin
        x_a <= 8'(pat(0, int'(rd_a[3:2]), int'(rd_a[1:0])));
        x_b <= 8'(pat(1, int'(rd_b[3:2]), int'(rd_b[1:0])));
        x_c <= 8'(pat(2, int'(rd_c[1]), int'(rd_c[0])));
    end

    function automatic logic start_of(input int i);
        case (i)
            0: return start_a;
            1: return start_b;
            default: return start_c;
        endcase
    endfunction

    task automatic set_start(input int i, input logic v);
        case (i)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    function automatic outs_t sample(input int i);
        outs_t s;
        case (i)
            0: begin s.wen = 32'(wen_a); s.busy = 32'(busy_a); s.done = 32'(done_a);
                     s.y = 32'(y_a); s.wr = 32'(wr_a); s.rd = 32'(rd_a); end
            1: begin s.wen = 32'(wen_b); s.busy = 32'(busy_b); s.done = 32'(done_b);
                     s.y = 32'(y_b); s.wr = 32'(wr_b); s.rd = 32'(rd_b); end
            default: begin s.wen = 32'(wen_c); s.busy = 32'(busy_c); s.done = 32'(done_c);
                     s.y = 32'(y_c); s.wr = 32'(wr_c); s.rd = 32'(rd_c); end
        endcase
        return s;
    endfunction

    // Model: k is the cycle number since the accepting edge (1 = PRIME).
    bit act [3];
    int kc  [3];

    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < 3; i++) begin
            if (RST || BC_mode) act[i] <= 1'b0;
            else if (act[i]) begin
                if (kc[i] >= 2 + 4 * (1 << (2 * (box_of(i) - 1)))) act[i] <= 1'b0;
                else kc[i] <= kc[i] + 1;
            end else if (start_of(i)) begin
                act[i] <= 1'b1;
                kc[i]  <= 1;
            end
        end
    end

    function automatic outs_t expect_out(input int i, input bit a, input int k);
        outs_t e;
        int b, m, w, c, p, cx, cy, cc;
        b = box_of(i);
        m = 1 << (b - 1);
        e.wen = 0; e.busy = 0; e.done = 0; e.y = 0; e.wr = 0; e.rd = 0;
        if (a) begin
            if (k == 1) e.busy = 1;
            else if (k >= 2 && k <= 1 + 4 * m * m) begin
                w = k - 2; c = w / 4; p = w % 4; cx = c % m; cy = c / m;
                e.wen  = 1;
                e.busy = 1;
                e.y    = 32'(pat(i, cx, cy) >> shift_of(i));
                e.wr   = 32'(((2 * cx + (p % 2)) << b) | (2 * cy + p / 2));
                cc     = (p == 3) ? (c + 1) % (m * m) : c;
                e.rd   = 32'(((cc % m) << (b - 1)) | (cc / m));
            end else if (k == 2 + 4 * m * m) e.done = 1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, got, got, exp, exp);
        end
    endtask

    logic [31:0] fine_m [3][64];
    int wlog [$];

    always @(negedge CLK) begin
        outs_t s, e;
        for (int i = 0; i < 3; i++) begin
            s = sample(i);
            e = expect_out(i, act[i], kc[i]);
            chk($sformatf("inst%0d wen", i),  s.wen,  e.wen);
            chk($sformatf("inst%0d busy", i), s.busy, e.busy);
            chk($sformatf("inst%0d done", i), s.done, e.done);
            chk($sformatf("inst%0d y", i),    s.y,    e.y);
            chk($sformatf("inst%0d wr", i),   s.wr,   e.wr);
            chk($sformatf("inst%0d rd", i),   s.rd,   e.rd);
            if (s.wen === 32'd1 && s.wr < 64) begin
                fine_m[i][s.wr] = s.y;
                if (i == 0) wlog.push_back(int'(s.wr));
            end
        end
    end

    int rd_hist [0:300];

    // mode: 0 plain, 1 BC_mode abort after 20 writes, 2 async RST in phase 2, 3 start while busy
    task automatic run_pass(input int i, input int mode, output int nwen, output int ndone,
                            output int done_k, output int first_wr, output int last_wr,
                            output int last_y, output int last_busy);
        outs_t s;
        int mm, step;
        mm = 1 << (2 * (box_of(i) - 1));
        nwen = 0; ndone = 0; done_k = -1; first_wr = -1; last_wr = -1; last_y = -1;
        last_busy = -1; step = 0;
        wlog.delete();
        @(posedge CLK); #2; set_start(i, 1'b1);
        @(posedge CLK); #2; set_start(i, 1'b0);
        for (int n = 1; n <= 4 * mm + 12; n++) begin
            @(negedge CLK);
            s = sample(i);
            rd_hist[n] = int'(s.rd);
            last_busy  = int'(s.busy);
            if (s.wen === 32'd1) begin
                nwen++;
                if (first_wr < 0) first_wr = int'(s.wr);
                last_wr = int'(s.wr);
                last_y  = int'(s.y);
            end
            if (s.done === 32'd1) begin
                ndone++;
                if (done_k < 0) done_k = n;
            end
            case (mode)
                1: begin
                    if (step == 1) begin
                        chk("abort wen", s.wen, 0);
                        chk("abort busy", s.busy, 0);
                        BC_mode = 1'b0;
                        step = 2;
                    end else if (step == 0 && nwen == 20) begin
                        BC_mode = 1'b1;
                        step = 1;
                    end
                end
                2: begin
                    if (step == 1) begin
                        #1 RST = 1'b0;
                        step = 2;
                    end else if (step == 0 && nwen >= 8 && s.wen === 32'd1 &&
                                 s.wr[3] == 1'b0 && s.wr[0] == 1'b1) begin
                        chk("pre-rst y", s.y, 2);
                        #1 RST = 1'b1;
                        #1;
                        s = sample(i);
                        chk("async rst wen", s.wen, 0);
                        chk("async rst busy", s.busy, 0);
                        chk("async rst y", s.y, 0);
                        step = 1;
                    end
                end
                3: begin
                    if (n == 10) set_start(i, 1'b1);
                    else if (n == 11) set_start(i, 1'b0);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        int nwen, ndone, done_k, first_wr, last_wr, last_y, last_busy, bad;
        outs_t s;
        int exp_order [8];
        exp_order = '{0, 8, 1, 9, 16, 24, 17, 25};

        repeat (3) @(negedge CLK);
        s = sample(0);
        chk("reset wen", s.wen, 0);
        chk("reset busy", s.busy, 0);
        chk("reset done", s.done, 0);
        chk("reset y", s.y, 0);
        chk("reset rd", s.rd, 0);
        chk("reset wr", s.wr, 0);
        @(posedge CLK); #2 RST = 1'b0;

        // Basic pass on BOX_IDX=3, no scaling.
        run_pass(0, 0, nwen, ndone, done_k, first_wr, last_wr, last_y, last_busy);
        chk("basic nwen", nwen, 64);
        chk("basic ndone", ndone, 1);
        chk("basic done cycle", done_k, 66);
        chk("basic busy after", last_busy, 0);
        chk("basic last wr", last_wr, 63);
        chk("basic last y", last_y, 8'h33);
        chk("fine {3,5}", fine_m[0][3 * 8 + 5], 8'h21);
        bad = 0;
        for (int fx = 0; fx < 8; fx++)
            for (int fy = 0; fy < 8; fy++)
                if (fine_m[0][fx * 8 + fy] !== 32'(16 * (fy >> 1) + (fx >> 1))) bad++;
        chk("fine grid bad cells", bad, 0);
        for (int j = 0; j < 8; j++)
            chk($sformatf("write order %0d", j), (wlog.size() > j) ? wlog[j] : -1, exp_order[j]);
        chk("rd prime", rd_hist[1], 0);
        chk("rd cell0 phase2", rd_hist[4], 0);
        chk("rd cell0 phase3", rd_hist[5], 4);
        chk("rd cell1 phase2", rd_hist[8], 4);
        chk("rd cell1 phase3", rd_hist[9], 8);

        // Scaling by 2 on cell {2,1} = 0xFF.
        run_pass(1, 0, nwen, ndone, done_k, first_wr, last_wr, last_y, last_busy);
        chk("scale nwen", nwen, 64);
        chk("scale {4,2}", fine_m[1][4 * 8 + 2], 8'h3F);
        chk("scale {5,2}", fine_m[1][5 * 8 + 2], 8'h3F);
        chk("scale {4,3}", fine_m[1][4 * 8 + 3], 8'h3F);
        chk("scale {5,3}", fine_m[1][5 * 8 + 3], 8'h3F);

        // BC_mode abort, then a clean full pass with an ignored start mid-run.
        run_pass(0, 1, nwen, ndone, done_k, first_wr, last_wr, last_y, last_busy);
        chk("abort nwen", nwen, 20);
        chk("abort ndone", ndone, 0);
        run_pass(0, 3, nwen, ndone, done_k, first_wr, last_wr, last_y, last_busy);
        chk("rerun nwen", nwen, 64);
        chk("rerun ndone", ndone, 1);
        chk("rerun first wr", first_wr, 0);
        chk("rerun done cycle", done_k, 66);

        // Async reset during phase 2.
        run_pass(0, 2, nwen, ndone, done_k, first_wr, last_wr, last_y, last_busy);
        chk("rst nwen", nwen, 11);
        chk("rst ndone", ndone, 0);

        // BOX_IDX=2 corner.
        run_pass(2, 0, nwen, ndone, done_k, first_wr, last_wr, last_y, last_busy);
        chk("box2 nwen", nwen, 16);
        chk("box2 ndone", ndone, 1);
        chk("box2 done cycle", done_k, 18);
        chk("box2 last wr", last_wr, 15);
        chk("box2 last y", last_y, 8'h11);

        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sqp.md
Name: sqp

Overview:
- Prolongation engine: the coarse-to-fine counterpart of the 2x2 restriction block.
- Scans a coarse grid of side M = 2^(BOX_IDX-1) held in box RAM, reading one coarse cell at a time.
- Writes each coarse value, scaled by right shift SCALE_SHIFT, to the four fine cells of the matching 2x2 block in a fine grid of side N = 2^BOX_IDX.
- Sits between the coarse-level RAM (1-cycle read latency) and the fine-level RAM write port.

Parameters:
- BOX_IDX, 3, log2 of fine-grid side; coarse side is 2^(BOX_IDX-1); must be >= 2.
- SCALE_SHIFT, 0, logical right shift applied to each coarse value before writing; legal range 0..7.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- BC_mode  in  1  synchronous abort/hold; while high the block is forced to IDLE.
- start  in  1  one-cycle request to run a full pass; sampled only in IDLE.
- x  in  8  coarse RAM read data, valid one cycle after rd_addr is presented.
- rd_addr  out  2*(BOX_IDX-1)  coarse read address {cx, cy}.
- wr_addr  out  2*BOX_IDX  fine write address {fx, fy}.
- wen  out  1  fine RAM write enable.
- y  out  8  fine RAM write data.
- busy  out  1  high in PRIME and WRITE.
- done  out  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset values (async RST): state IDLE, cx=cy=0, phase=0, hold=0, rd_addr=0, wr_addr=0, wen=0, y=0, busy=0, done=0.
- BC_mode=1 at a clock edge produces the same register values as RST; that cycle's start is ignored.
- States:
  - IDLE: rd_addr={0,0}. start=1 -> PRIME.
  - PRIME: one cycle; rd_addr={cx,cy}={0,0} presented -> WRITE with phase=0.
  - WRITE: phase 0..3, four cycles per coarse cell, wen=1 in every WRITE cycle.
  - DONE: done=1 for one cycle -> IDLE.
- Phase 0 data: y = x >> SCALE_SHIFT, taken directly from RAM data; x is captured into hold.
- Phases 1..3 data: y = hold >> SCALE_SHIFT.
- Fine address per phase (fx=2cx+phase[0], fy=2cy+phase[1]):
  - phase0 (2cx, 2cy)
  - phase1 (2cx+1, 2cy)
  - phase2 (2cx, 2cy+1)
  - phase3 (2cx+1, 2cy+1)
- Coarse scan order: cx fastest. cx wraps M-1 -> 0 and increments cy.
- Read pipelining:
  - In phase 3, rd_addr already shows the next cell, so its data arrives at the next phase 0 with no bubble.
  - Once the next cell is presented in phase 3, rd_addr holds that value until the next phase 3.
- Last cell (cx=M-1, cy=M-1): after phase 3 -> DONE. cx/cy wrap to 0; the final rd_addr is don't-care, driven {0,0}.
- Latency (start seen in IDLE at edge 0):
  - PRIME in cycle 1.
  - Writes in cycles 2 .. 1+4*M^2.
  - done in cycle 2+4*M^2 (66 for BOX_IDX=3).
- start while busy or in DONE: ignored; no queuing.
- Reset or BC_mode mid-pass: immediate return to IDLE. No partial completion signalled; done stays 0.
- Counter widths: cx, cy are BOX_IDX-1 bits with natural wrap. phase is 2 bits. No arithmetic overflow is possible.

Decomposition:
- Shared package (sqg_pkg):
  - state enum IDLE/PRIME/WRITE/DONE.
  - DATA_W=8.
  - Helpers for coarse side (1<<(BOX_IDX-1)) and address widths; these are shared with the restriction block.
- One natural sub-module: sqp_addr_gen.
  - Owns cx/cy/phase counters and produces rd_addr, wr_addr, last_cell.
  - Top level keeps the FSM, hold register and data path.

Test Plan:
- Basic pass, BOX_IDX=3, SCALE_SHIFT=0: coarse RAM model holds value = 16*cy + cx. Pulse start -> exactly 64 wen cycles. Fine cell (fx,fy) gets 16*(fy>>1) + (fx>>1), e.g. wr_addr {3,5} writes 0x21. done pulses in cycle 66, busy low afterwards.
- Write order: first 8 writes -> wr_addr {0,0},{1,0},{0,1},{1,1},{2,0},{3,0},{2,1},{3,1}. rd_addr sequence {0,0},{1,0},{2,0}, changing only in PRIME/phase 3.
- Scaling, SCALE_SHIFT=2: coarse cell {2,1} = 0xFF -> its four fine cells ({4,2},{5,2},{4,3},{5,3}) receive 0x3F.
- Abort: BC_mode=1 asserted after 20 writes -> next cycle wen=0, busy=0, no done. A new start then yields a full 64-write pass from {0,0}.
- Async reset: RST asserted mid-cycle during phase 2 -> wen, busy, y drop to 0 before the next clock edge. start pulsed while busy is ignored, giving exactly one done per accepted start.
- BOX_IDX=2 corner: M=2 -> 16 writes, done in cycle 18. The last write is to wr_addr {3,3} with data from coarse cell {1,1}.
